ingress_admit_writer: RTL and testbench

- Write-side stage that sits directly upstream of the dual-clock packet FIFO in each switch ingress port.
- Takes a sop/eop-framed word stream from the port receiver and reads the length field from the header word.
- Admits a packet only if the whole packet fits in the FIFO's current free space; otherwise drops it whole, so the FIFO never holds a partial packet and never overflows.
- Also handles malformed framing and keeps per-port packet and drop counters.

---
 rtl/ingress_admit_writer_if.sv | 28 ++
 rtl/ingress_admit_writer.sv | 149 ++++++++++++++
 tb/tb_ingress_admit_writer.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_admit_writer_if.sv
// Word-stream and FIFO write-port bundle between the port receiver,
// the admission stage and the dual-clock packet FIFO.
interface ingress_admit_writer_if #(
    parameter int DATA_BIT = 16,
    parameter int CNT_BIT  = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_BIT-1:0] in_data;
    logic                in_sop;
    logic                in_eop;
    logic                fifo_wr_en;
    logic [DATA_BIT-1:0] fifo_wr_data;
    logic [CNT_BIT-1:0]  fifo_wr_cnt;
    logic                fifo_full;

    // Environment side: drives the word stream and the FIFO status.
    modport master (
        output in_valid, in_data, in_sop, in_eop, fifo_wr_cnt, fifo_full,
        input  in_ready, fifo_wr_en, fifo_wr_data
    );

    // Admission stage side.
    modport slave (
        input  in_valid, in_data, in_sop, in_eop, fifo_wr_cnt, fifo_full,
        output in_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/ingress_admit_writer.sv
// Ingress admission writer: holds each packet header, lets the FIFO fill
// count settle, then admits the whole packet only if it fits in the free
// space, otherwise drops it whole. Flags malformed framing and keeps
// admitted/dropped packet counters.
module ingress_admit_writer #(
    parameter int DATA_BIT   = 16,
    parameter int CNT_BIT    = 4,
    parameter int FIFO_WORDS = 16,
    parameter int LEN_BIT    = 5,
    parameter int STAT_BIT   = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst_n,
    ingress_admit_writer_if.slave bus,
    output logic [STAT_BIT-1:0]  pkt_cnt,
    output logic [STAT_BIT-1:0]  drop_cnt,
    output logic                 err
);

    // Common width for comparing the header length against free space.
    localparam int CMP_BIT = (LEN_BIT > CNT_BIT + 1) ? LEN_BIT : CNT_BIT + 1;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DECIDE,
        FWD,
        DROP
    } state_t;

    state_t              state;
    logic                settle_cnt;
    logic [LEN_BIT-1:0]  len;
    logic [LEN_BIT-1:0]  word_cnt;
    logic [LEN_BIT-1:0]  word_cnt_nxt;
    logic                wr_en_q;
    logic [DATA_BIT-1:0] wr_data_q;
    logic                ready_c;
    logic                accept;
    logic [CNT_BIT:0]    free;
    logic                admit_ok;

    // Ready decode: the header is held in IDLE, a stray word is swallowed,
    // and FWD/DROP take every word offered.
    always_comb begin
        // NOTE: default first so no path through the case leaves ready_c
        // unassigned, which would otherwise infer a latch.
        ready_c = 1'b0;
        unique case (state)
            IDLE:      ready_c = bus.in_valid && !bus.in_sop;
            FWD, DROP: ready_c = 1'b1;
            default:   ready_c = 1'b0;
        endcase
    end

    // ready_c is combinational from state and inputs; gating with rst_n
    // keeps it low while reset is held even if a stray word is offered.
    assign bus.in_ready = rst_n && ready_c;
    assign accept       = bus.in_valid && bus.in_ready;
    assign word_cnt_nxt = word_cnt + 1'b1;

    // Admission decision from the settled fill count and the latched length.
    always_comb begin
        free     = bus.fifo_full ? '0
                 : (CNT_BIT+1)'(FIFO_WORDS) - {1'b0, bus.fifo_wr_cnt};
        admit_ok = (len != '0)
                && (CMP_BIT'(len) <= CMP_BIT'(FIFO_WORDS))
                && (CMP_BIT'(len) <= CMP_BIT'(free));
    end

    // Packet FSM with registered FIFO write port, counters and error pulse.
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= 1'b0;
            len        <= '0;
            word_cnt   <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // below sees the pre-edge values of all state registers.
            wr_en_q <= 1'b0;
            err     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_sop) begin
                        settle_cnt <= 1'b0;
                        state      <= SETTLE;
                    end else if (accept) begin
                        err <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Two stall cycles let the FIFO's registered fill count
                    // catch up with the last word written by this block.
                    if (!settle_cnt) begin
                        len        <= bus.in_data[LEN_BIT-1:0];
                        settle_cnt <= 1'b1;
                    end else begin
                        state <= DECIDE;
                    end
                end
                DECIDE: begin
                    word_cnt <= '0;
                    if (admit_ok) begin
                        state <= FWD;
                    end else begin
                        drop_cnt <= drop_cnt + 1'b1;
                        state    <= DROP;
                    end
                end
                FWD: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= bus.in_data;
                        word_cnt  <= word_cnt_nxt;
                        if (bus.in_eop) begin
                            // Short packet is still counted; what was
                            // written stays in the FIFO.
                            pkt_cnt <= pkt_cnt + 1'b1;
                            err     <= (word_cnt_nxt != len);
                            state   <= IDLE;
                        end else if (word_cnt_nxt == len) begin
                            // Long packet: keep the declared length, discard
                            // the tail up to its eop.
                            pkt_cnt <= pkt_cnt + 1'b1;
                            err     <= 1'b1;
                            state   <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && bus.in_eop) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = wr_data_q;

endmodule

// File: tb/tb_ingress_admit_writer.sv
// Directed bench for ingress_admit_writer: admission, no-room drop,
// full-flag drop, bad lengths, back-to-back with a non-draining FIFO,
// framing errors and reset in the middle of a packet.
module tb_ingress_admit_writer;

    localparam int DATA_BIT = 16;
    localparam int CNT_BIT  = 4;
    localparam int STAT_BIT = 16;

    logic                wr_clk = 1'b0;
    logic                rst_n;
    logic [STAT_BIT-1:0] pkt_cnt;
    logic [STAT_BIT-1:0] drop_cnt;
    logic                err;

    always #5 wr_clk = ~wr_clk;

    ingress_admit_writer_if #(.DATA_BIT(DATA_BIT), .CNT_BIT(CNT_BIT)) bus ();

    ingress_admit_writer #(
        .DATA_BIT(DATA_BIT), .CNT_BIT(CNT_BIT), .FIFO_WORDS(16),
        .LEN_BIT(5), .STAT_BIT(STAT_BIT)
    ) dut (
        .wr_clk   (wr_clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt),
        .err      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_hits = 0;

    logic [15:0] wr_q[$];
    int          wr_cyc[$];
    int          acc_cyc[$];

    // FIFO status: fixed values, or a non-draining FIFO that counts writes.
    logic       model_on = 1'b0;
    logic [4:0] fill;
    logic [3:0] set_cnt  = 4'd0;
    logic       set_full = 1'b0;

    assign bus.fifo_wr_cnt = model_on ? fill[3:0] : set_cnt;
    assign bus.fifo_full   = model_on ? (fill == 5'd16) : set_full;

    always @(posedge wr_clk) begin
        cyc <= cyc + 1;
        if (!model_on)            fill <= 5'd0;
        else if (bus.fifo_wr_en)  fill <= fill + 5'd1;
    end

    // Monitor: log FIFO writes and err pulses mid-cycle.
    always @(negedge wr_clk) begin
        if (bus.fifo_wr_en) begin
            wr_q.push_back(bus.fifo_wr_data);
            wr_cyc.push_back(cyc);
        end
        if (err) err_hits++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    // Offer one word; stall returns the number of cycles in_ready was low.
    task automatic send_word(input logic [15:0] d, input logic s, input logic e,
                             output int stall);
        bit done = 1'b0;
        stall        = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = s;
        bus.in_eop   = e;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge wr_clk);
            if (bus.in_ready) begin
                done = 1'b1;
                acc_cyc.push_back(cyc);
            end else begin
                stall++;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL accept_timeout: word %h got no in_ready, required within 40 cycles", d);
        end
        @(posedge wr_clk);
        #1;
    endtask

    // Header word hdr with sop, then base+1 .. base+(n-1); eop on the last.
    task automatic send_pkt(input logic [15:0] hdr, input logic [15:0] base,
                            input int n, output int hdr_stall);
        int st;
        hdr_stall = 0;
        for (int i = 0; i < n; i++) begin
            send_word((i == 0) ? hdr : base + 16'(i), i == 0, i == n - 1, st);
            if (i == 0) hdr_stall = st;
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b0;
        bus.in_eop   = 1'b0;
        bus.in_data  = 16'h5555;
        #12;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", bus.fifo_wr_en); end
        n_checks++; if (bus.fifo_wr_data !== 16'h0000) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0000", bus.fifo_wr_data); end
        n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        idle();
        @(negedge wr_clk);
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    task automatic test_admit();
        logic [15:0] exp_w [4];
        int w0, a0, e0, stall;
        exp_w = '{16'h0004, 16'hA001, 16'hA002, 16'hA003};
        w0 = wr_q.size(); a0 = acc_cyc.size(); e0 = err_hits;
        send_pkt(16'h0004, 16'hA000, 4, stall);
        wait_cycles(3);
        // Presenting cycle plus SETTLE, SETTLE, DECIDE.
        n_checks++; if (stall !== 4) begin n_fail++; $display("FAIL admit_hdr_stall: got %0d expected 4", stall); end
        n_checks++; if (wr_q.size() - w0 !== 4) begin n_fail++; $display("FAIL admit_wr_count: got %0d expected 4", wr_q.size() - w0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wr_q.size() <= w0 + i || wr_q[w0 + i] !== exp_w[i]) begin
                n_fail++;
                $display("FAIL admit_data[%0d]: got %h expected %h", i,
                         (wr_q.size() > w0 + i) ? wr_q[w0 + i] : 16'h0000, exp_w[i]);
            end
            n_checks++;
            if (wr_cyc.size() <= w0 + i || acc_cyc.size() <= a0 + i ||
                wr_cyc[w0 + i] !== acc_cyc[a0 + i] + 1) begin
                n_fail++;
                $display("FAIL admit_wr_timing[%0d]: write cycle %0d, expected acceptance cycle + 1 = %0d", i,
                         (wr_cyc.size() > w0 + i) ? wr_cyc[w0 + i] : -1,
                         (acc_cyc.size() > a0 + i) ? acc_cyc[a0 + i] + 1 : -1);
            end
        end
        n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL admit_pkt_cnt: got %0d expected 1", pkt_cnt); end
        n_checks++; if (err_hits !== e0) begin n_fail++; $display("FAIL admit_err: got %0d pulses expected 0", err_hits - e0); end
    endtask

    task automatic test_no_room();
        int w0, stall;
        set_cnt = 4'd14;
        w0 = wr_q.size();
        send_pkt(16'h0003, 16'hB000, 3, stall);
        wait_cycles(3);
        n_checks++; if (wr_q.size() !== w0) begin n_fail++; $display("FAIL noroom_writes: got %0d expected 0", wr_q.size() - w0); end
        n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL noroom_drop_cnt: got %0d expected 1", drop_cnt); end
        w0 = wr_q.size();
        send_pkt(16'h0002, 16'hC000, 2, stall);
        wait_cycles(3);
        n_checks++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL fit_writes: got %0d expected 2", wr_q.size() - w0); end
        n_checks++;
        if (wr_q.size() < w0 + 2 || wr_q[w0] !== 16'h0002 || wr_q[w0 + 1] !== 16'hC001) begin
            n_fail++;
            $display("FAIL fit_data: got %h %h expected 0002 c001",
                     (wr_q.size() > w0) ? wr_q[w0] : 16'h0, (wr_q.size() > w0 + 1) ? wr_q[w0 + 1] : 16'h0);
        end
        n_checks++; if (pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL fit_pkt_cnt: got %0d expected 2", pkt_cnt); end
        set_cnt = 4'd0;
    endtask

    task automatic test_full_flag();
        int w0, stall;
        w0 = wr_q.size();
        // Full with a wrapped count of 0: free must be 0.
        set_full = 1'b1;
        send_pkt(16'h0001, 16'h0000, 1, stall);
        wait_cycles(3);
        n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL full_drop_cnt: got %0d expected 2", drop_cnt); end
        set_full = 1'b0;
        // Length 17 exceeds the FIFO; length 0 is invalid.
        send_pkt(16'h0011, 16'h0000, 1, stall);
        send_pkt(16'h0000, 16'h0000, 1, stall);
        wait_cycles(3);
        n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL badlen_drop_cnt: got %0d expected 4", drop_cnt); end
        n_checks++; if (wr_q.size() !== w0) begin n_fail++; $display("FAIL full_writes: got %0d expected 0", wr_q.size() - w0); end
        n_checks++; if (pkt_cnt !== 16'd2) begin n_fail++; $display("FAIL full_pkt_cnt: got %0d expected 2", pkt_cnt); end
    endtask

    task automatic test_back_to_back();
        int w0, stall;
        model_on = 1'b1;
        wait_cycles(1);
        w0 = wr_q.size();
        send_pkt(16'h0010, 16'hD000, 16, stall);
        send_pkt(16'h0001, 16'h0000, 1, stall);
        wait_cycles(3);
        n_checks++; if (wr_q.size() - w0 !== 16) begin n_fail++; $display("FAIL b2b_writes: got %0d expected 16", wr_q.size() - w0); end
        n_checks++;
        if (wr_q.size() < w0 + 16 || wr_q[w0] !== 16'h0010 || wr_q[w0 + 15] !== 16'hD00F) begin
            n_fail++;
            $display("FAIL b2b_data: first/last got %h %h expected 0010 d00f",
                     (wr_q.size() > w0) ? wr_q[w0] : 16'h0, (wr_q.size() > w0 + 15) ? wr_q[w0 + 15] : 16'h0);
        end
        n_checks++; if (pkt_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_pkt_cnt: got %0d expected 3", pkt_cnt); end
        n_checks++; if (drop_cnt !== 16'd5) begin n_fail++; $display("FAIL b2b_drop_cnt: got %0d expected 5", drop_cnt); end
        model_on = 1'b0;
        wait_cycles(1);
    endtask

    task automatic test_framing();
        int w0, e0, stall;
        // Stray word in IDLE.
        w0 = wr_q.size(); e0 = err_hits;
        send_word(16'h1234, 1'b0, 1'b0, stall);
        idle();
        wait_cycles(3);
        n_checks++; if (stall !== 0) begin n_fail++; $display("FAIL stray_stall: got %0d expected 0", stall); end
        n_checks++; if (err_hits - e0 !== 1) begin n_fail++; $display("FAIL stray_err: got %0d pulses expected 1", err_hits - e0); end
        n_checks++; if (wr_q.size() !== w0) begin n_fail++; $display("FAIL stray_writes: got %0d expected 0", wr_q.size() - w0); end
        // Short packet: len 3, eop on word 2.
        w0 = wr_q.size(); e0 = err_hits;
        send_pkt(16'h0003, 16'hE000, 2, stall);
        wait_cycles(3);
        n_checks++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL short_writes: got %0d expected 2", wr_q.size() - w0); end
        n_checks++; if (err_hits - e0 !== 1) begin n_fail++; $display("FAIL short_err: got %0d pulses expected 1", err_hits - e0); end
        n_checks++; if (pkt_cnt !== 16'd4) begin n_fail++; $display("FAIL short_pkt_cnt: got %0d expected 4", pkt_cnt); end
        // Long packet: len 2, eop on word 4.
        w0 = wr_q.size(); e0 = err_hits;
        send_pkt(16'h0002, 16'hF000, 4, stall);
        wait_cycles(3);
        n_checks++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL long_writes: got %0d expected 2", wr_q.size() - w0); end
        n_checks++;
        if (wr_q.size() < w0 + 2 || wr_q[w0 + 1] !== 16'hF001) begin
            n_fail++;
            $display("FAIL long_data: got %h expected f001", (wr_q.size() > w0 + 1) ? wr_q[w0 + 1] : 16'h0);
        end
        n_checks++; if (err_hits - e0 !== 1) begin n_fail++; $display("FAIL long_err: got %0d pulses expected 1", err_hits - e0); end
        n_checks++; if (pkt_cnt !== 16'd5) begin n_fail++; $display("FAIL long_pkt_cnt: got %0d expected 5", pkt_cnt); end
        n_checks++; if (drop_cnt !== 16'd5) begin n_fail++; $display("FAIL long_drop_cnt: got %0d expected 5", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        int w0, stall;
        send_word(16'h0005, 1'b1, 1'b0, stall);
        send_word(16'h9001, 1'b0, 1'b0, stall);
        n_checks++; if (bus.fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_wr_en: got %b expected 1", bus.fifo_wr_en); end
        bus.in_data = 16'h9002;
        rst_n       = 1'b0;
        #1;
        n_checks++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_wr_en: got %b expected 0", bus.fifo_wr_en); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b expected 0", bus.in_ready); end
        n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_pkt_cnt: got %0d expected 0", pkt_cnt); end
        n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_drop_cnt: got %0d expected 0", drop_cnt); end
        idle();
        @(negedge wr_clk);
        rst_n = 1'b1;
        wait_cycles(1);
        w0 = wr_q.size();
        send_pkt(16'h0002, 16'h7000, 2, stall);
        wait_cycles(3);
        n_checks++; if (wr_q.size() - w0 !== 2) begin n_fail++; $display("FAIL postrst_writes: got %0d expected 2", wr_q.size() - w0); end
        n_checks++;
        if (wr_q.size() < w0 + 2 || wr_q[w0] !== 16'h0002 || wr_q[w0 + 1] !== 16'h7001) begin
            n_fail++;
            $display("FAIL postrst_data: got %h %h expected 0002 7001",
                     (wr_q.size() > w0) ? wr_q[w0] : 16'h0, (wr_q.size() > w0 + 1) ? wr_q[w0 + 1] : 16'h0);
        end
        n_checks++; if (pkt_cnt !== 16'd1) begin n_fail++; $display("FAIL postrst_pkt_cnt: got %0d expected 1", pkt_cnt); end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_admit();
        test_no_room();
        test_full_flag();
        test_back_to_back();
        test_framing();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
